// File: rtl/baud_tick_gen.sv
// Multi-channel UART timing source: per-channel rx oversample and tx bit clock-enable strobes.
// Optional fractional divisor enabled by defining BAUD_TICK_GEN_FRAC_EN.
module baud_tick_gen #(
   parameter int NUM_CH     = 2,
   parameter int DIV_W      = 16,
   parameter int OVERSAMPLE = 16,
   parameter int FRAC_W     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         en,
   input  logic [NUM_CH*DIV_W-1:0]   div,
`ifdef BAUD_TICK_GEN_FRAC_EN
   input  logic [NUM_CH*FRAC_W-1:0]  frac,
`endif
   input  logic [NUM_CH-1:0]         sync,
   output logic [NUM_CH-1:0]         rx_tick,
   output logic [NUM_CH-1:0]         tx_tick,
   output logic [NUM_CH-1:0]         busy
);

   localparam int OS_W = $clog2(OVERSAMPLE);

   if (OVERSAMPLE < 2 || FRAC_W < 1) begin : g_param_check
      $error("baud_tick_gen: OVERSAMPLE must be >= 2 and FRAC_W >= 1");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] div_act;
      logic [DIV_W-1:0] div_in;
      logic [OS_W-1:0]  os_cnt;
      logic             rx_q;
      logic             tx_q;
      logic             busy_q;
      logic             terminal;

      assign div_in     = div[i*DIV_W +: DIV_W];
      assign rx_tick[i] = rx_q;
      assign tx_tick[i] = tx_q;
      assign busy[i]    = busy_q;

`ifdef BAUD_TICK_GEN_FRAC_EN
      logic [FRAC_W-1:0] acc;
      logic [FRAC_W-1:0] frac_act;
      logic [FRAC_W-1:0] frac_in;
      logic [FRAC_W:0]   acc_sum;
      logic              stretch;

      assign frac_in  = frac[i*FRAC_W +: FRAC_W];
      assign acc_sum  = {1'b0, acc} + {1'b0, frac_act};
      // A pending carry holds the count at div_act for one extra cycle.
      assign terminal = (cnt == div_act) && !stretch;
`else
      assign terminal = (cnt == div_act);
`endif

      // div_act follows the live divisor whenever the channel is idle or in reset, so a
      // channel held enabled through reset restarts with a full div+1 first period.
      always_ff @(posedge clk) begin
         if (reset || !en[i]) begin
            cnt     <= '0;
            os_cnt  <= '0;
            div_act <= div_in;
            rx_q    <= 1'b0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BAUD_TICK_GEN_FRAC_EN
            acc      <= '0;
            frac_act <= frac_in;
            stretch  <= 1'b0;
`endif
         end else begin
            busy_q <= 1'b1;
            rx_q   <= 1'b0;
            tx_q   <= 1'b0;
            if (sync[i]) begin
               cnt    <= '0;
               os_cnt <= '0;
`ifdef BAUD_TICK_GEN_FRAC_EN
               acc     <= '0;
               stretch <= 1'b0;
`endif
            end else if (terminal) begin
               cnt     <= '0;
               div_act <= div_in;
               rx_q    <= 1'b1;
               tx_q    <= (os_cnt == OS_W'(OVERSAMPLE - 1));
               os_cnt  <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
`ifdef BAUD_TICK_GEN_FRAC_EN
               {stretch, acc} <= acc_sum;
               frac_act       <= frac_in;
`endif
            end
`ifdef BAUD_TICK_GEN_FRAC_EN
            else if (cnt == div_act) begin
               stretch <= 1'b0;
            end
`endif
            else begin
               cnt <= cnt + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen (default build, no fractional divisor).
// A time-based model predicts each channel's tick edges; random traffic closes out the run.
module tb_baud_tick_gen;
   localparam int NUM_CH = 2;
   localparam int DIV_W  = 16;
   localparam int OS     = 16;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NUM_CH-1:0]       en;
   logic [NUM_CH*DIV_W-1:0] div;
   logic [NUM_CH-1:0]       sync;
   logic [NUM_CH-1:0]       rx_tick;
   logic [NUM_CH-1:0]       tx_tick;
   logic [NUM_CH-1:0]       busy;

   int errors = 0;
   int checks = 0;

   // Model: absolute edge index of the next expected rx tick per channel.
   int                cyc = 0;
   bit                active  [NUM_CH];
   int                next_t  [NUM_CH];
   int                div_lat [NUM_CH];
   int                nticks  [NUM_CH];
   logic [NUM_CH-1:0] exp_rx;
   logic [NUM_CH-1:0] exp_tx;
   logic [NUM_CH-1:0] exp_busy;

   always #5 clk = ~clk;

   baud_tick_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .OVERSAMPLE(OS)) dut (
      .clk(clk), .reset(reset), .en(en), .div(div), .sync(sync),
      .rx_tick(rx_tick), .tx_tick(tx_tick), .busy(busy)
   );

   task automatic set_div(input int ch, input int v);
      logic [DIV_W-1:0] w;
      w = v[DIV_W-1:0];
      div[ch*DIV_W +: DIV_W] = w;
   endtask

   // Advance one clock edge, update the model from the inputs seen at that edge.
   task automatic tick();
      @(posedge clk);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         int d;
         d = int'(div[ch*DIV_W +: DIV_W]);
         exp_rx[ch] = 1'b0;
         exp_tx[ch] = 1'b0;
         if (reset || !en[ch]) begin
            active[ch]   = 1'b0;
            div_lat[ch]  = d;
            exp_busy[ch] = 1'b0;
         end else begin
            exp_busy[ch] = 1'b1;
            if (!active[ch]) begin
               active[ch] = 1'b1;
               nticks[ch] = 0;
               next_t[ch] = cyc + div_lat[ch];
            end
            if (sync[ch]) begin
               next_t[ch] = cyc + div_lat[ch] + 1;
               nticks[ch] = 0;
            end else if (cyc == next_t[ch]) begin
               exp_rx[ch]  = 1'b1;
               nticks[ch]  = nticks[ch] + 1;
               exp_tx[ch]  = (nticks[ch] % OS == 0);
               div_lat[ch] = d;
               next_t[ch]  = cyc + d + 1;
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = '0; sync = '0; div = '0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({rx_tick, tx_tick, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs cyc %0d: got rx=%b tx=%b busy=%b want all 0", cyc, rx_tick, tx_tick, busy);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int rx_cnt = 0;
      int tx_cnt = 0;
      set_div(0, 3);
      set_div(1, int'($urandom_range(9, 0)));
      en = 2'b01;
      for (int k = 0; k < 128; k++) begin
         tick();
         rx_cnt += int'(rx_tick[0]);
         tx_cnt += int'(tx_tick[0]);
         checks++;
         if (rx_tick !== exp_rx) begin errors++; $display("[TB] FAIL basic_rx cyc %0d: got %b want %b", cyc, rx_tick, exp_rx); end
         checks++;
         if (tx_tick !== exp_tx) begin errors++; $display("[TB] FAIL basic_tx cyc %0d: got %b want %b", cyc, tx_tick, exp_tx); end
         checks++;
         if (busy !== exp_busy) begin errors++; $display("[TB] FAIL basic_busy cyc %0d: got %b want %b", cyc, busy, exp_busy); end
      end
      checks++;
      if (rx_cnt != 32) begin errors++; $display("[TB] FAIL basic_rx_count: got %0d want 32", rx_cnt); end
      checks++;
      if (tx_cnt != 2) begin errors++; $display("[TB] FAIL basic_tx_count: got %0d want 2", tx_cnt); end
   endtask

   task automatic test_reload();
      int calls = 0;
      int first = -1;
      int second = -1;
      int third = -1;
      for (int k = 0; k < 8 && (next_t[0] - cyc) != 2; k++) tick();
      set_div(0, 7);
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (rx_tick[0]) begin
            if (first < 0) first = k; else if (second < 0) second = k; else if (third < 0) third = k;
         end
         checks++;
         if (rx_tick !== exp_rx) begin errors++; $display("[TB] FAIL reload_rx cyc %0d: got %b want %b", cyc, rx_tick, exp_rx); end
         checks++;
         if (tx_tick !== exp_tx) begin errors++; $display("[TB] FAIL reload_tx cyc %0d: got %b want %b", cyc, tx_tick, exp_tx); end
      end
      checks++;
      if (first != 3) begin errors++; $display("[TB] FAIL reload_current_period: first tick at %0d want 3", first); end
      checks++;
      if (second - first != 8 || third - second != 8) begin
         errors++; $display("[TB] FAIL reload_new_period: gaps %0d,%0d want 8,8", second - first, third - second);
      end
      calls = third;
   endtask

   task automatic test_sync();
      int gap = -1;
      int rxs = 0;
      int tx_at = -1;
      set_div(0, 3);
      for (int k = 0; k < 40; k++) tick();
      for (int k = 0; k < 10 && next_t[0] != cyc; k++) tick();
      sync = 2'b01;
      tick();
      sync = '0;
      checks++;
      if (rx_tick[0] !== 1'b0) begin errors++; $display("[TB] FAIL sync_suppress: got rx=%b want 0", rx_tick[0]); end
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (rx_tick[0]) begin
            rxs++;
            if (gap < 0) gap = k;
         end
         if (tx_tick[0] && tx_at < 0) tx_at = rxs;
         checks++;
         if (rx_tick !== exp_rx) begin errors++; $display("[TB] FAIL sync_rx cyc %0d: got %b want %b", cyc, rx_tick, exp_rx); end
         checks++;
         if (tx_tick !== exp_tx) begin errors++; $display("[TB] FAIL sync_tx cyc %0d: got %b want %b", cyc, tx_tick, exp_tx); end
      end
      checks++;
      if (gap != 4) begin errors++; $display("[TB] FAIL sync_next_tick: got %0d cycles want 4", gap); end
      checks++;
      if (tx_at != 16) begin errors++; $display("[TB] FAIL sync_tx_phase: tx on rx tick %0d want 16", tx_at); end
   endtask

   task automatic test_div_zero();
      int ones = 0;
      int txs = 0;
      set_div(0, 0);
      for (int k = 0; k < 8; k++) tick();
      for (int k = 0; k < 48; k++) begin
         tick();
         ones += int'(rx_tick[0]);
         txs  += int'(tx_tick[0]);
         checks++;
         if (rx_tick !== exp_rx) begin errors++; $display("[TB] FAIL div0_rx cyc %0d: got %b want %b", cyc, rx_tick, exp_rx); end
         checks++;
         if (tx_tick !== exp_tx) begin errors++; $display("[TB] FAIL div0_tx cyc %0d: got %b want %b", cyc, tx_tick, exp_tx); end
      end
      checks++;
      if (ones != 48 || txs != 3) begin errors++; $display("[TB] FAIL div0_counts: rx=%0d tx=%0d want 48 and 3", ones, txs); end
      en = 2'b00;
      tick();
      checks++;
      if ({rx_tick[0], tx_tick[0], busy[0]} !== 3'b000) begin
         errors++; $display("[TB] FAIL div0_disable: got rx=%b tx=%b busy=%b want 0", rx_tick[0], tx_tick[0], busy[0]);
      end
   endtask

   task automatic test_reset_mid();
      int lat = -1;
      set_div(0, 3);
      en = 2'b01;
      for (int k = 0; k < 12; k++) tick();
      for (int k = 0; k < 8 && (next_t[0] - cyc) != 1; k++) tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({rx_tick, tx_tick, busy} !== '0) begin
         errors++; $display("[TB] FAIL reset_mid_outputs: got rx=%b tx=%b busy=%b want 0", rx_tick, tx_tick, busy);
      end
      reset = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (rx_tick[0] && lat < 0) lat = k;
         checks++;
         if (rx_tick !== exp_rx) begin errors++; $display("[TB] FAIL reset_mid_rx cyc %0d: got %b want %b", cyc, rx_tick, exp_rx); end
      end
      checks++;
      if (lat != 4) begin errors++; $display("[TB] FAIL reset_mid_latency: got %0d want 4", lat); end
   endtask

   task automatic test_random();
      en = 2'b11;
      for (int k = 0; k < 900; k++) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if ($urandom_range(59, 0) == 0) en[ch] = ~en[ch];
            if ($urandom_range(19, 0) == 0) set_div(ch, int'($urandom_range(12, 0)));
            sync[ch] = ($urandom_range(39, 0) == 0);
         end
         reset = ($urandom_range(299, 0) == 0);
         tick();
         checks++;
         if (rx_tick !== exp_rx) begin errors++; $display("[TB] FAIL random_rx cyc %0d: got %b want %b", cyc, rx_tick, exp_rx); end
         checks++;
         if (tx_tick !== exp_tx) begin errors++; $display("[TB] FAIL random_tx cyc %0d: got %b want %b", cyc, tx_tick, exp_tx); end
         checks++;
         if (busy !== exp_busy) begin errors++; $display("[TB] FAIL random_busy cyc %0d: got %b want %b", cyc, busy, exp_busy); end
      end
      reset = 1'b0;
      sync  = '0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reload();
      test_sync();
      test_div_zero();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
